// File: rtl/processador_pkg.sv
// Shared definitions for the processador multicycle core: opcodes, control
// step encoding and the selector for the single internal datapath bus.
package processador_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b1000;
  localparam logic [3:0] OP_MVI = 4'b1010;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    BUS_ZERO = 3'd0,
    BUS_RX   = 3'd1,
    BUS_RY   = 3'd2,
    BUS_IMM  = 3'd3,
    BUS_G    = 3'd4
  } bus_src_t;

  // Opcodes that run the three-step A/G sequence through the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/processador_alu.sv
// Combinational 16-bit ALU: o_y = i_a <op> i_b, wrapping arithmetic, no flags.
module processador_alu
  import processador_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  // Operation select; non-ALU opcodes produce zero (the result is never stored for them).
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/processador_core.sv
// Multicycle 16-bit processor core: eight GPRs, accumulator A, result
// register G, instruction register IR and a fixed four-step control sequence
// sharing a single datapath bus. One instruction is consumed every 4 clocks.
// Note: resetn is active-high despite its name.
module processador_core
  import processador_pkg::*;
(
  input  logic              clock,
  input  logic [DATA_W-1:0] iin,
  input  logic              resetn,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_ir;
  step_t             r_step;

  logic [3:0]        w_op;
  logic [2:0]        w_rx;
  logic [2:0]        w_ry;
  logic [DATA_W-1:0] w_imm;
  bus_src_t          w_src;
  logic              w_wr_rx;
  logic              w_wr_a;
  logic              w_wr_g;
  logic [DATA_W-1:0] w_bus_mux;
  logic [DATA_W-1:0] w_alu_y;

  assign w_op  = r_ir[15:12];
  assign w_rx  = r_ir[11:9];
  assign w_ry  = r_ir[8:6];
  assign w_imm = {10'b0, r_ir[5:0]};

  // Control decode: choose the bus source and register enables for the current step.
  always_comb begin
    w_src   = BUS_ZERO;
    w_wr_rx = 1'b0;
    w_wr_a  = 1'b0;
    w_wr_g  = 1'b0;
    case (r_step)
      T1: begin
        if (w_op == OP_MV) begin
          w_src   = BUS_RY;
          w_wr_rx = 1'b1;
        end else if (w_op == OP_MVI) begin
          w_src   = BUS_IMM;
          w_wr_rx = 1'b1;
        end else if (is_alu_op(w_op)) begin
          w_src  = BUS_RX;
          w_wr_a = 1'b1;
        end
      end
      T2: begin
        if (is_alu_op(w_op)) begin
          w_src  = BUS_RY;
          w_wr_g = 1'b1;
        end
      end
      T3: begin
        if (is_alu_op(w_op)) begin
          w_src   = BUS_G;
          w_wr_rx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus multiplexer; forced to zero while reset is held so an aborted step shows nothing.
  always_comb begin
    w_bus_mux = '0;
    case (w_src)
      BUS_RX:  w_bus_mux = r_regs[w_rx];
      BUS_RY:  w_bus_mux = r_regs[w_ry];
      BUS_IMM: w_bus_mux = w_imm;
      BUS_G:   w_bus_mux = r_g;
      default: w_bus_mux = '0;
    endcase
  end

  assign bus = resetn ? '0 : w_bus_mux;

  processador_alu u_alu (
    .i_op (w_op),
    .i_a  (r_a),
    .i_b  (bus),
    .o_y  (w_alu_y)
  );

  // Step sequencer and instruction capture; IR is loaded only in T0.
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_step <= T0;
      r_ir   <= '0;
    end else begin
      case (r_step)
        T0: begin
          r_ir   <= iin;
          r_step <= T1;
        end
        T1:      r_step <= T2;
        T2:      r_step <= T3;
        default: r_step <= T0;
      endcase
    end
  end

  // Register file, accumulator and ALU result register; reset wins over any pending write.
  always_ff @(posedge clock) begin
    if (resetn) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_a <= '0;
      r_g <= '0;
    end else begin
      if (w_wr_rx) r_regs[w_rx] <= bus;
      if (w_wr_a)  r_a          <= bus;
      if (w_wr_g)  r_g          <= w_alu_y;
    end
  end

endmodule

// File: tb/tb_processador_core.sv
// Self-checking bench for processador_core. A per-instruction reference model
// predicts the bus value in each of the four steps and the resulting register
// contents; register contents are observed through "mv Rk,Rk" probes.
module tb_processador_core;

  logic        clock;
  logic [15:0] iin;
  logic        resetn;
  logic [15:0] bus;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_regs [8];

  processador_core dut (
    .clock  (clock),
    .iin    (iin),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] enc(input logic [3:0] op, input int x, input int y,
                                      input logic [5:0] imm);
    logic [2:0] xx;
    logic [2:0] yy;
    xx = x[2:0];
    yy = y[2:0];
    return {op, xx, yy, imm};
  endfunction

  // Instruction-level model: expected bus per step, and architectural update.
  function automatic void model_exec(input logic [15:0] instr, output logic [3:0][15:0] exp);
    int op, x, y;
    logic [15:0] a, b, r;
    op = int'(instr[15:12]);
    x  = int'(instr[11:9]);
    y  = int'(instr[8:6]);
    exp = '0;
    a = m_regs[x];
    b = m_regs[y];
    case (op)
      0: begin exp[1] = b; m_regs[x] = b; end
      10: begin exp[1] = 16'(instr[5:0]); m_regs[x] = 16'(instr[5:0]); end
      2, 3, 4, 5, 6: begin
        case (op)
          2: r = 16'((int'(a) + int'(b)) % 65536);
          3: r = 16'((int'(a) - int'(b) + 65536) % 65536);
          4: r = a & b;
          5: r = a | b;
          default: r = a ^ b;
        endcase
        exp[1] = a; exp[2] = b; exp[3] = r;
        m_regs[x] = r;
      end
      default: ;
    endcase
  endfunction

  // Drives one instruction starting in T0 (called at a negedge) and captures the bus per step.
  task automatic run_instr(input logic [15:0] instr, output logic [3:0][15:0] got);
    got[0] = bus;
    iin = instr;
    for (int s = 1; s < 4; s++) begin
      @(posedge clock);
      @(negedge clock);
      got[s] = bus;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [3:0][15:0] got, exp;
    resetn = 1'b1;
    iin = 16'hFFFF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0000", bus);
    end
    resetn = 1'b0;
    for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
    for (int k = 0; k < 8; k++) begin
      run_instr(enc(4'b0000, k, k, 6'd0), got);
      model_exec(enc(4'b0000, k, k, 6'd0), exp);
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (got[s] !== exp[s]) begin
          errors++;
          $display("FAIL reset_R%0d_step%0d: got %h want %h", k, s, got[s], exp[s]);
        end
      end
    end
  endtask

  task automatic test_mvi();
    logic [3:0][15:0] got, exp;
    run_instr(16'b1010_000_000_011100, got);
    model_exec(16'b1010_000_000_011100, exp);
    checks++;
    if (got !== exp || got[1] !== 16'd28) begin
      errors++;
      $display("FAIL mvi_R0: got %h want %h", got, exp);
    end
    run_instr(16'b1010_010_000_001010, got);
    model_exec(16'b1010_010_000_001010, exp);
    checks++;
    if (got !== exp || got[1] !== 16'd10) begin
      errors++;
      $display("FAIL mvi_R2: got %h want %h", got, exp);
    end
  endtask

  task automatic test_add();
    logic [3:0][15:0] got, exp;
    run_instr(16'b0010_000_010_000000, got);
    model_exec(16'b0010_000_010_000000, exp);
    checks++;
    if (got !== exp || got[3] !== 16'd38) begin
      errors++;
      $display("FAIL add_R0_R2: got %h want %h", got, exp);
    end
    run_instr(enc(4'b0000, 0, 0, 6'd0), got);
    checks++;
    if (got[1] !== 16'd38) begin
      errors++;
      $display("FAIL add_R0_result: got %h want 0026", got[1]);
    end
  endtask

  task automatic test_nop();
    logic [3:0][15:0] got, exp;
    run_instr(16'b1000_000_000_000000, got);
    model_exec(16'b1000_000_000_000000, exp);
    checks++;
    if (got !== 64'h0) begin
      errors++;
      $display("FAIL nop_bus: got %h want all zero", got);
    end
    run_instr(enc(4'b0000, 0, 0, 6'd0), got);
    checks++;
    if (got[1] !== 16'd38) begin
      errors++;
      $display("FAIL nop_R0: got %h want 0026", got[1]);
    end
    run_instr(enc(4'b0000, 2, 2, 6'd0), got);
    checks++;
    if (got[1] !== 16'd10) begin
      errors++;
      $display("FAIL nop_R2: got %h want 000a", got[1]);
    end
  endtask

  task automatic test_sub_wrap();
    logic [3:0][15:0] got, exp;
    logic [15:0] prog [3];
    prog[0] = enc(4'b1010, 3, 0, 6'd0);
    prog[1] = enc(4'b1010, 4, 0, 6'd1);
    prog[2] = 16'b0011_011_100_000000;
    for (int i = 0; i < 3; i++) begin
      run_instr(prog[i], got);
      model_exec(prog[i], exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sub_wrap_%0d: got %h want %h", i, got, exp);
      end
    end
    checks++;
    if (got[3] !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_wrap_value: got %h want ffff", got[3]);
    end
  endtask

  task automatic test_logic_mv();
    logic [3:0][15:0] got, exp;
    logic [15:0] prog [9];
    prog[0] = enc(4'b1010, 5, 0, 6'h0F);
    prog[1] = enc(4'b1010, 6, 0, 6'h3C);
    prog[2] = enc(4'b0100, 5, 6, 6'd0);
    prog[3] = enc(4'b0000, 7, 5, 6'd0);
    prog[4] = enc(4'b0000, 7, 7, 6'd0);
    prog[5] = enc(4'b1010, 5, 0, 6'h0F);
    prog[6] = enc(4'b0101, 5, 6, 6'd0);
    prog[7] = enc(4'b1010, 1, 0, 6'h0F);
    prog[8] = enc(4'b0110, 1, 6, 6'd0);
    for (int i = 0; i < 9; i++) begin
      run_instr(prog[i], got);
      model_exec(prog[i], exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL logic_mv_%0d: got %h want %h", i, got, exp);
      end
      if (i == 2 || i == 4) begin
        checks++;
        if (got[i == 2 ? 3 : 1] !== 16'h000C) begin
          errors++;
          $display("FAIL logic_mv_const_%0d: got %h want 000c", i, got[i == 2 ? 3 : 1]);
        end
      end
    end
  endtask

  task automatic test_same_reg();
    logic [3:0][15:0] got, exp;
    logic [15:0] prog [4];
    prog[0] = enc(4'b1010, 1, 0, 6'd21);
    prog[1] = enc(4'b0010, 1, 1, 6'd0);
    prog[2] = enc(4'b0000, 0, 0, 6'd0);
    prog[3] = enc(4'b0000, 1, 1, 6'd0);
    for (int i = 0; i < 4; i++) begin
      run_instr(prog[i], got);
      model_exec(prog[i], exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL same_reg_%0d: got %h want %h", i, got, exp);
      end
    end
    checks++;
    if (got[1] !== 16'd42) begin
      errors++;
      $display("FAIL same_reg_double: got %h want 002a", got[1]);
    end
  endtask

  task automatic test_random();
    logic [3:0][15:0] got, exp;
    logic [15:0] instr;
    for (int i = 0; i < 80; i++) begin
      instr = 16'($urandom);
      run_instr(instr, got);
      model_exec(instr, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d instr %h: got %h want %h", i, instr, got, exp);
      end
    end
    for (int k = 0; k < 8; k++) begin
      run_instr(enc(4'b0000, k, k, 6'd0), got);
      model_exec(enc(4'b0000, k, k, 6'd0), exp);
      checks++;
      if (got[1] !== exp[1]) begin
        errors++;
        $display("FAIL random_final_R%0d: got %h want %h", k, got[1], exp[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][15:0] got, exp;
    logic [15:0] instr;
    for (int i = 0; i < 16; i++) begin
      instr = (i % 2 == 0) ? enc(4'b1010, i % 8, 0, 6'($urandom)) : enc(4'b0011, i % 8, (i + 3) % 8, 6'd0);
      run_instr(instr, got);
      model_exec(instr, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0][15:0] got, exp;
    run_instr(enc(4'b1010, 0, 0, 6'd5), got);
    model_exec(enc(4'b1010, 0, 0, 6'd5), exp);
    run_instr(enc(4'b1010, 2, 0, 6'd7), got);
    model_exec(enc(4'b1010, 2, 0, 6'd7), exp);
    iin = enc(4'b0010, 0, 2, 6'd0);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus !== 16'd5) begin
      errors++;
      $display("FAIL mid_reset_T1: got %h want 0005", bus);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus !== 16'd7) begin
      errors++;
      $display("FAIL mid_reset_T2: got %h want 0007", bus);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (bus !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_bus_in_reset: got %h want 0000", bus);
    end
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
    for (int k = 0; k < 8; k++) begin
      run_instr(enc(4'b0000, k, k, 6'd0), got);
      checks++;
      if (got !== 64'h0) begin
        errors++;
        $display("FAIL mid_reset_R%0d: got %h want all zero", k, got);
      end
    end
    run_instr(enc(4'b0010, 0, 0, 6'd0), got);
    model_exec(enc(4'b0010, 0, 0, 6'd0), exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h want %h", got, exp);
    end
  endtask

  initial begin
    resetn = 1'b1;
    iin = 16'h0;
    test_reset();
    test_mvi();
    test_add();
    test_nop();
    test_sub_wrap();
    test_logic_mv();
    test_same_reg();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
